// File: rtl/hit_list_readout_pkg.sv
// Shared widths, HCM field layout and FSM state encoding for the hit-list readout.
package hit_list_readout_pkg;

  localparam int unsigned SSID_BITS_DEF      = 10;
  localparam int unsigned COL_INDEX_BITS_DEF = 5;
  localparam int unsigned ROW_INDEX_BITS_DEF = SSID_BITS_DEF - COL_INDEX_BITS_DEF;
  localparam int unsigned MAX_HIT_N_BITS_DEF = 4;
  localparam int unsigned HLM_ADDR_BITS_DEF  = 10;

  // HCM word: count in the low bits, HLM address occupies the top of the word.
  localparam int unsigned HCM_COUNT_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ROW,
    S_LOAD_ROW,
    S_SCAN,
    S_HCM_WAIT,
    S_HCM_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/hit_list_readout_if.sv
// Valid/ready record stream from the hit-list readout to pattern matching.
interface hit_list_readout_if
  import hit_list_readout_pkg::*;
#(
  parameter int unsigned SSIDBITS    = SSID_BITS_DEF,
  parameter int unsigned MAXHITNBITS = MAX_HIT_N_BITS_DEF,
  parameter int unsigned HLMADDRBITS = HLM_ADDR_BITS_DEF
);

  logic                   outValid;
  logic                   outReady;
  logic [SSIDBITS-1:0]    outSSID;
  logic [MAXHITNBITS-1:0] outCount;
  logic [HLMADDRBITS-1:0] outHLMAddress;

  modport master (
    output outValid,
    output outSSID,
    output outCount,
    output outHLMAddress,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outSSID,
    input  outCount,
    input  outHLMAddress,
    output outReady
  );

endinterface

// File: rtl/hit_list_readout_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_bit_encoder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IDXBITS = 5
) (
  input  logic [WIDTH-1:0]   bits,
  output logic [IDXBITS-1:0] index,
  output logic               any_set
);

  // First set bit scanning upward wins, which keeps SSIDs ascending within a row.
  always_comb begin
    index   = '0;
    any_set = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bits[i] && !any_set) begin
        index   = IDXBITS'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_list_readout.sv
// Scans the hits-new memory row by row and emits {SSID, count, HLM address}
// for every set hit bit, reading counts from the hits-count memory.
module hit_list_readout
  import hit_list_readout_pkg::*;
#(
  parameter  int unsigned SSIDBITS     = SSID_BITS_DEF,
  parameter  int unsigned COLINDEXBITS = COL_INDEX_BITS_DEF,
  parameter  int unsigned ROWINDEXBITS = SSIDBITS - COLINDEXBITS,
  parameter  int unsigned MAXHITNBITS  = MAX_HIT_N_BITS_DEF,
  parameter  int unsigned HLMADDRBITS  = HLM_ADDR_BITS_DEF,
  localparam int unsigned NCOLS        = 1 << COLINDEXBITS,
  localparam int unsigned HCMBITS      = MAXHITNBITS + HLMADDRBITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    countError,
  output logic [ROWINDEXBITS-1:0] hnmAddr,
  input  logic [NCOLS-1:0]        hnmData,
  output logic [SSIDBITS-1:0]     hcmAddr,
  input  logic [HCMBITS-1:0]      hcmData,
  hit_list_readout_if.master      stream
);

  state_t                  state, state_n;
  logic [ROWINDEXBITS-1:0] row, row_n, hnm_addr_n;
  logic [NCOLS-1:0]        row_bits, row_bits_n;
  logic [SSIDBITS-1:0]     hcm_addr_n;
  logic                    count_error_n;
  logic                    out_valid, out_valid_n;
  logic [SSIDBITS-1:0]     out_ssid, out_ssid_n;
  logic [MAXHITNBITS-1:0]  out_count, out_count_n;
  logic [HLMADDRBITS-1:0]  out_hlm, out_hlm_n;
  logic [COLINDEXBITS-1:0] col;
  logic                    any_set;
  logic [MAXHITNBITS-1:0]  hcm_count;
  logic [HLMADDRBITS-1:0]  hcm_hlm;

  assign hcm_count = hcmData[HCM_COUNT_LSB +: MAXHITNBITS];
  assign hcm_hlm   = hcmData[HCMBITS-1 -: HLMADDRBITS];

  lowest_set_bit_encoder #(
    .WIDTH   (NCOLS),
    .IDXBITS (COLINDEXBITS)
  ) u_lsb_enc (
    .bits    (row_bits),
    .index   (col),
    .any_set (any_set)
  );

  assign busy                 = (state != S_IDLE);
  assign done                 = (state == S_DONE);
  assign stream.outValid      = out_valid;
  assign stream.outSSID       = out_ssid;
  assign stream.outCount      = out_count;
  assign stream.outHLMAddress = out_hlm;

  // Next-state and next-datapath values; everything holds unless a state updates it.
  always_comb begin
    state_n       = state;
    row_n         = row;
    row_bits_n    = row_bits;
    hnm_addr_n    = hnmAddr;
    hcm_addr_n    = hcmAddr;
    count_error_n = countError;
    out_valid_n   = out_valid;
    out_ssid_n    = out_ssid;
    out_count_n   = out_count;
    out_hlm_n     = out_hlm;
    case (state)
      S_IDLE: begin
        if (start) begin
          row_n         = '0;
          hnm_addr_n    = '0;
          count_error_n = 1'b0;
          state_n       = S_FETCH_ROW;
        end
      end
      S_FETCH_ROW: state_n = S_LOAD_ROW;
      S_LOAD_ROW: begin
        row_bits_n = hnmData;
        state_n    = S_SCAN;
      end
      S_SCAN: begin
        if (!any_set) begin
          if (row == '1) begin
            state_n = S_DONE;
          end else begin
            row_n      = row + ROWINDEXBITS'(1);
            hnm_addr_n = row + ROWINDEXBITS'(1);
            state_n    = S_FETCH_ROW;
          end
        end else begin
          // x & (x-1) drops exactly the bit the encoder just selected.
          row_bits_n = row_bits & (row_bits - NCOLS'(1));
          hcm_addr_n = {row, col};
          state_n    = S_HCM_WAIT;
        end
      end
      S_HCM_WAIT: state_n = S_HCM_LOAD;
      S_HCM_LOAD: begin
        if (hcm_count != '0) begin
          out_ssid_n  = hcmAddr;
          out_count_n = hcm_count;
          out_hlm_n   = hcm_hlm;
          out_valid_n = 1'b1;
          state_n     = S_EMIT;
        end else begin
          count_error_n = 1'b1;
          state_n       = S_SCAN;
        end
      end
      S_EMIT: begin
        if (stream.outReady) begin
          out_valid_n = 1'b0;
          state_n     = S_SCAN;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Datapath registers: scan position, RAM addresses and the output record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row        <= '0;
      row_bits   <= '0;
      hnmAddr    <= '0;
      hcmAddr    <= '0;
      countError <= 1'b0;
      out_valid  <= 1'b0;
      out_ssid   <= '0;
      out_count  <= '0;
      out_hlm    <= '0;
    end else begin
      row        <= row_n;
      row_bits   <= row_bits_n;
      hnmAddr    <= hnm_addr_n;
      hcmAddr    <= hcm_addr_n;
      countError <= count_error_n;
      out_valid  <= out_valid_n;
      out_ssid   <= out_ssid_n;
      out_count  <= out_count_n;
      out_hlm    <= out_hlm_n;
    end
  end

endmodule

// File: tb/tb_hit_list_readout.sv
// Scoreboard bench for hit_list_readout with behavioural HNM/HCM B-port models.
module tb_hit_list_readout;

  typedef struct {
    logic [9:0] ssid;
    logic [3:0] cnt;
    logic [9:0] hlm;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, countError;
  logic [4:0]  hnmAddr;
  logic [31:0] hnmData;
  logic [9:0]  hcmAddr;
  logic [13:0] hcmData;

  logic [31:0] hnm_mem [32];
  logic [13:0] hcm_mem [1024];

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hit_list_readout_if #(.SSIDBITS(10), .MAXHITNBITS(4), .HLMADDRBITS(10)) stream ();

  hit_list_readout #(
    .SSIDBITS     (10),
    .COLINDEXBITS (5),
    .MAXHITNBITS  (4),
    .HLMADDRBITS  (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .countError (countError),
    .hnmAddr    (hnmAddr),
    .hnmData    (hnmData),
    .hcmAddr    (hcmAddr),
    .hcmData    (hcmData),
    .stream     (stream.master)
  );

  always #5 clock = ~clock;

  // Synchronous RAM read ports with one cycle of latency.
  always @(posedge clock) begin
    hnmData <= hnm_mem[hnmAddr];
    hcmData <= hcm_mem[hcmAddr];
  end

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every valid cycle must present the head record; pop on handshake.
  always @(negedge clock) begin
    if (!reset && stream.outValid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record_ssid", stream.outSSID, 10'h3ff + 1);
      end else begin
        chk("record", {stream.outSSID, stream.outCount, stream.outHLMAddress},
            {exp_q[0].ssid, exp_q[0].cnt, exp_q[0].hlm});
        if (stream.outReady) void'(exp_q.pop_front());
      end
    end
  end

  task automatic clear_mem();
    foreach (hnm_mem[i]) hnm_mem[i] = '0;
    foreach (hcm_mem[i]) hcm_mem[i] = '0;
  endtask

  task automatic push(input int ssid, input int cnt, input int hlm);
    rec_t r;
    r.ssid = 10'(ssid);
    r.cnt  = 4'(cnt);
    r.hlm  = 10'(hlm);
    exp_q.push_back(r);
  endtask

  // Called at #1 after an edge; the next edge (edge 0) samples start.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  function automatic logic ready_at(int edge_n, int stall_from, int stall_len);
    return !(edge_n >= stall_from && edge_n < stall_from + stall_len);
  endfunction

  // Counts edges after edge 0 until done is seen; checks timing and wind-down.
  task automatic run_scan(input int exp_done, input int exp_first,
                          input int stall_from, input int stall_len, input int start_at);
    int k = 0;
    int first = -1;
    bit got_done = 0;
    stream.outReady = ready_at(1, stall_from, stall_len);
    for (int c = 0; c < 2000 && !got_done; c++) begin
      @(posedge clock);
      k++;
      #1;
      start = (k == start_at);
      stream.outReady = ready_at(k + 1, stall_from, stall_len);
      if (stream.outValid && first < 0) first = k;
      if (done) got_done = 1;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("done_edge", k, exp_done);
    if (exp_first >= 0) chk("first_valid_edge", first, exp_first);
    chk("busy_in_done", busy, 1);
    @(posedge clock);
    #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("queue_drained", exp_q.size(), 0);
    stream.outReady = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_countError"}, countError, 0);
    chk({tag, "_outValid"}, stream.outValid, 0);
    chk({tag, "_outSSID"}, stream.outSSID, 0);
    chk({tag, "_outCount"}, stream.outCount, 0);
    chk({tag, "_outHLM"}, stream.outHLMAddress, 0);
    chk({tag, "_hnmAddr"}, hnmAddr, 0);
    chk({tag, "_hcmAddr"}, hcmAddr, 0);
  endtask

  task automatic load_two_hits();
    clear_mem();
    hnm_mem[0] = 32'h0000_0005;
    hcm_mem[0] = {10'd3, 4'd2};
    hcm_mem[2] = {10'd7, 4'd1};
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stream.outReady = 1'b1;
    clear_mem();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Empty memory: 3 cycles per row, 32 rows.
    pulse_start();
    run_scan(96, -1, 0, 0, 0);

    // Two hits in row 0.
    load_two_hits();
    push(0, 2, 3);
    push(2, 1, 7);
    pulse_start();
    run_scan(104, 5, 0, 0, 0);

    // Column/row boundaries and the last SSID.
    clear_mem();
    hnm_mem[0]    = 32'h8000_0000;
    hnm_mem[1]    = 32'h0000_0001;
    hnm_mem[31]   = 32'h8000_0000;
    hcm_mem[31]   = {10'd100, 4'd5};
    hcm_mem[32]   = {10'd200, 4'd15};
    hcm_mem[1023] = {10'd1023, 4'd9};
    push(31, 5, 100);
    push(32, 15, 200);
    push(1023, 9, 1023);
    pulse_start();
    run_scan(108, 5, 0, 0, 0);

    // Back-pressure: ready low on edges 6..15.
    load_two_hits();
    push(0, 2, 3);
    push(2, 1, 7);
    pulse_start();
    run_scan(114, 5, 6, 10, 0);

    // Zero-count entry at SSID 40 is skipped and flagged.
    clear_mem();
    hnm_mem[1]  = 32'h0000_0300;
    hcm_mem[41] = {10'd55, 4'd6};
    push(41, 6, 55);
    pulse_start();
    run_scan(103, 11, 0, 0, 0);
    chk("countError_set", countError, 1);
    clear_mem();
    pulse_start();
    chk("countError_cleared", countError, 0);
    run_scan(96, -1, 0, 0, 0);

    // Reset while a record is held in EMIT.
    load_two_hits();
    push(0, 2, 3);
    push(2, 1, 7);
    stream.outReady = 1'b0;
    pulse_start();
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    chk("valid_before_reset", stream.outValid, 1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    stream.outReady = 1'b1;

    // Rescan from SSID 0; a start pulse mid-scan must not retrigger.
    push(0, 2, 3);
    push(2, 1, 7);
    pulse_start();
    run_scan(104, 5, 0, 0, 50);
    @(posedge clock);
    #1;
    chk("no_queued_start", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_list_readout.md
# hit_list_readout

Downstream readout stage for hit storage. Once a storage round is complete, it scans every row of the hits-new memory (HNM) and finds each SSID whose hit bit is set. For each such SSID it reads the hits-count memory (HCM) entry and emits one record {SSID, hit count, HLM address} on a valid/ready stream to the pattern-matching logic. It drives only the B-side read ports of HNM and HCM, and must not run while storage is writing or clearing.

## Interface

Parameters:

- SSIDBITS, 10: SSID width; HCM address width.
- COLINDEXBITS, 5: SSID low bits that select the HNM column. HNM word is 2^COLINDEXBITS bits.
- ROWINDEXBITS, SSIDBITS-COLINDEXBITS: HNM address width. NROWS = 2^ROWINDEXBITS.
- MAXHITNBITS, 4: width of the HCM count field, HCM[MAXHITNBITS-1:0].
- HLMADDRBITS, 10: width of the HCM HLM-address field, HCM[top HLMADDRBITS bits]. HCM word = MAXHITNBITS + HLMADDRBITS.

Ports:

- clock, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: begin a scan; sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of a scan.
- countError, out, 1: sticky flag; cleared by an accepted start.
- hnmAddr, out, ROWINDEXBITS: HNM B-port address.
- hnmData, in, 2^COLINDEXBITS: HNM B-port data; 1-cycle read latency.
- hcmAddr, out, SSIDBITS: HCM B-port address.
- hcmData, in, HCM word: HCM B-port data; 1-cycle read latency.
- outValid, out, 1: output record valid.
- outReady, in, 1: consumer accepts the record.
- outSSID, out, SSIDBITS: SSID of the record.
- outCount, out, MAXHITNBITS: hit count of the record.
- outHLMAddress, out, HLMADDRBITS: HLM address of the record.

## Operation

- FSM states: IDLE, FETCH_ROW, LOAD_ROW, SCAN, HCM_WAIT, HCM_LOAD, EMIT, DONE.
- IDLE, start=1: row←0, hnmAddr←0, countError←0, go to FETCH_ROW.
- FETCH_ROW: wait for RAM latency, then go to LOAD_ROW.
- LOAD_ROW: rowBits←hnmData, then go to SCAN.
- SCAN with rowBits=0:
  - if row=NROWS-1, go to DONE;
  - otherwise row←row+1, hnmAddr←row+1, go to FETCH_ROW.
- SCAN with rowBits≠0:
  - col←index of the lowest set bit; clear that bit in rowBits;
  - hcmAddr←{row,col}; go to HCM_WAIT.
- HCM_WAIT: go to HCM_LOAD.
- HCM_LOAD, count field ≠0: latch outSSID={row,col}, outCount and outHLMAddress from hcmData; set outValid←1; go to EMIT.
- HCM_LOAD, count field =0: this is an inconsistent entry. Set countError←1, emit nothing, return to SCAN.
- EMIT: hold all out* fields stable. On outValid&&outReady, clear outValid and return to SCAN.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Output order: SSIDs strictly ascending.
- Row and column counters never wrap inside a scan. The last row terminates the scan.
- start outside IDLE is ignored; there is no queueing.
- Reset values: all of the following are 0 and the state is IDLE:
  - busy, done, countError, outValid;
  - outSSID, outCount, outHLMAddress;
  - hnmAddr, hcmAddr.
- Reset mid-scan aborts immediately. A record in flight is dropped and is not re-emitted.

## Timing

- Edge 0 is the edge that samples start.
- Each row with no hits costs 3 cycles (FETCH_ROW, LOAD_ROW, SCAN).
- Each emitted hit adds 4 cycles (SCAN, HCM_WAIT, HCM_LOAD, EMIT) when outReady is held high. Each cycle of outReady=0 in EMIT adds 1 more cycle.
- A zero-count skip costs 3 cycles.
- First record, hit at SSID 0: outValid rises after edge 5.
- Empty memory: DONE is entered at edge 3·NROWS. done is high for the following cycle. busy falls after edge 3·NROWS+1.
- outValid stays high without change until the handshake completes; out* fields never change while outValid=1.

## Structure

- Shared package/header additions:
  - SSID/row/column widths;
  - HCM field offsets: count LSB=0; HLM-address MSB = word top;
  - FSM state encoding constants.
- One natural sub-module: lowest_set_bit_encoder. It is combinational, width 2^COLINDEXBITS, and outputs the index plus an any-set flag.
- The RAMs stay outside this block. The top level gives the B ports to this block while busy=1 and to storage otherwise.

## Test plan

- Empty HNM, NROWS=32, start pulse → no outValid; done pulses once after edge 96; busy low afterwards.
- HNM row 0 = 32'h0000_0005; HCM[0]={HLM 3, count 2}; HCM[2]={HLM 7, count 1}; outReady=1 → two records:
  - (SSID 0, 2, 3) with outValid rising after edge 5;
  - (SSID 2, 1, 7).
- Hits at SSIDs 31, 32 and 1023 → records emitted in that order; the last row terminates the scan with no wrap.
- outReady low for 10 cycles on the first record → out* fields held stable; no record lost or duplicated; done delayed by 10 cycles.
- HNM bit set at SSID 40 with HCM[40] count=0 → no record for SSID 40; countError=1 after the scan; the next start clears it.
- Assert reset mid-EMIT → all outputs 0 and state IDLE immediately. A new start rescans from SSID 0; a start pulse during busy has no effect.
